// File: rtl/ipd_match_ctrl.sv
// ipd_match_ctrl: sequences one iterated Prisoner's Dilemma match between two players
module ipd_match_ctrl #(
  parameter int NUM_ROUNDS = 200,
  parameter int ROUND_W    = 8,
  parameter int SCORE_W    = 16,
  parameter int PAY_T      = 5,
  parameter int PAY_R      = 3,
  parameter int PAY_P      = 1,
  parameter int PAY_S      = 0,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ROUND_W-1:0] cfg_rounds,
  output logic               player_rst,
  output logic               round_req,
  input  logic               act_a_valid,
  input  logic               act_a,
  input  logic               act_b_valid,
  input  logic               act_b,
  output logic               opp_to_a,
  output logic               opp_to_b,
  output logic [ROUND_W-1:0] round_idx,
  output logic               last_round,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [ROUND_W-1:0] coop_a,
  output logic [ROUND_W-1:0] coop_b,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int SW1 = SCORE_W + 1;
  localparam logic [SCORE_W:0] PT = SW1'(PAY_T);
  localparam logic [SCORE_W:0] PR = SW1'(PAY_R);
  localparam logic [SCORE_W:0] PP = SW1'(PAY_P);
  localparam logic [SCORE_W:0] PS = SW1'(PAY_S);
  typedef enum logic [2:0] {IDLE, INIT, REQ, SCORE, UPDATE, DONE} state_t;
  state_t             state;
  logic [ROUND_W-1:0] rounds;
  logic [TW-1:0]      wait_cnt;
  logic               got_a, got_b, act_a_r, act_b_r;
  logic               have_a, have_b, expired, is_last;
  logic [SCORE_W:0]   pay_a, pay_b, sum_a, sum_b;
  assign have_a     = got_a | act_a_valid;
  assign have_b     = got_b | act_b_valid;
  assign expired    = wait_cnt == TW'(TIMEOUT - 1);
  assign is_last    = round_idx == rounds - ROUND_W'(1);
  assign last_round = busy & is_last;
  always_comb begin
    pay_a = act_a_r ? (act_b_r ? PP : PT) : (act_b_r ? PS : PR);
    pay_b = act_b_r ? (act_a_r ? PP : PT) : (act_a_r ? PS : PR);
    sum_a = {1'b0, score_a} + pay_a;
    sum_b = {1'b0, score_b} + pay_b;
  end
  // Outputs are registered alongside the state so each one tracks its state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rounds      <= '0;
      wait_cnt    <= '0;
      got_a       <= 1'b0;
      got_b       <= 1'b0;
      act_a_r     <= 1'b0;
      act_b_r     <= 1'b0;
      player_rst  <= 1'b0;
      round_req   <= 1'b0;
      opp_to_a    <= 1'b0;
      opp_to_b    <= 1'b0;
      round_idx   <= '0;
      score_a     <= '0;
      score_b     <= '0;
      coop_a      <= '0;
      coop_b      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rounds      <= cfg_rounds == '0 ? ROUND_W'(NUM_ROUNDS) : cfg_rounds;
          score_a     <= '0;
          score_b     <= '0;
          coop_a      <= '0;
          coop_b      <= '0;
          round_idx   <= '0;
          opp_to_a    <= 1'b0;
          opp_to_b    <= 1'b0;
          timeout_err <= 1'b0;
          player_rst  <= 1'b1;
          busy        <= 1'b1;
          state       <= INIT;
        end
        INIT: begin
          player_rst <= 1'b0;
          round_req  <= 1'b1;
          wait_cnt   <= '0;
          got_a      <= 1'b0;
          got_b      <= 1'b0;
          state      <= REQ;
        end
        REQ: begin
          if (!got_a && act_a_valid) begin
            got_a   <= 1'b1;
            act_a_r <= act_a;
          end
          if (!got_b && act_b_valid) begin
            got_b   <= 1'b1;
            act_b_r <= act_b;
          end
          if (have_a && have_b) begin
            round_req <= 1'b0;
            state     <= SCORE;
          end else if (expired) begin
            // A silent player is treated as defecting.
            if (!have_a) act_a_r <= 1'b1;
            if (!have_b) act_b_r <= 1'b1;
            timeout_err <= 1'b1;
            round_req   <= 1'b0;
            state       <= SCORE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        SCORE: begin
          score_a <= sum_a[SCORE_W] ? '1 : sum_a[SCORE_W-1:0];
          score_b <= sum_b[SCORE_W] ? '1 : sum_b[SCORE_W-1:0];
          coop_a  <= coop_a + ROUND_W'(!act_a_r);
          coop_b  <= coop_b + ROUND_W'(!act_b_r);
          state   <= UPDATE;
        end
        UPDATE: begin
          opp_to_a <= act_b_r;
          opp_to_b <= act_a_r;
          if (is_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            round_idx <= round_idx + ROUND_W'(1);
            round_req <= 1'b1;
            wait_cnt  <= '0;
            got_a     <= 1'b0;
            got_b     <= 1'b0;
            state     <= REQ;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipd_match_ctrl.sv
// tb_ipd_match_ctrl: scoreboard bench; d0 uses default parameters, d1 a 4-bit score and 8-cycle timeout
module tb_ipd_match_ctrl;
  typedef struct {int sa; int sb; int ca; int cb; int te;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic       start0 = 0, av0 = 0, a0 = 0, bv0 = 0, b0 = 0;
  logic [7:0] cfg0 = '0;
  logic       player_rst0, round_req0, opp_to_a0, opp_to_b0, last_round0, busy0, done0, timeout_err0;
  logic [7:0] round_idx0, coop_a0, coop_b0;
  logic [15:0] score_a0, score_b0;
  logic       start1 = 0, av1 = 0, a1 = 0, bv1 = 0, b1 = 0;
  logic [7:0] cfg1 = '0;
  logic       player_rst1, round_req1, opp_to_a1, opp_to_b1, last_round1, busy1, done1, timeout_err1;
  logic [7:0] round_idx1, coop_a1, coop_b1;
  logic [3:0] score_a1, score_b1;
  ipd_match_ctrl d0 (
    .clk(clk), .reset(reset), .start(start0), .cfg_rounds(cfg0),
    .player_rst(player_rst0), .round_req(round_req0),
    .act_a_valid(av0), .act_a(a0), .act_b_valid(bv0), .act_b(b0),
    .opp_to_a(opp_to_a0), .opp_to_b(opp_to_b0), .round_idx(round_idx0), .last_round(last_round0),
    .score_a(score_a0), .score_b(score_b0), .coop_a(coop_a0), .coop_b(coop_b0),
    .busy(busy0), .done(done0), .timeout_err(timeout_err0)
  );
  ipd_match_ctrl #(.SCORE_W(4), .TIMEOUT(8)) d1 (
    .clk(clk), .reset(reset), .start(start1), .cfg_rounds(cfg1),
    .player_rst(player_rst1), .round_req(round_req1),
    .act_a_valid(av1), .act_a(a1), .act_b_valid(bv1), .act_b(b1),
    .opp_to_a(opp_to_a1), .opp_to_b(opp_to_b1), .round_idx(round_idx1), .last_round(last_round1),
    .score_a(score_a1), .score_b(score_b1), .coop_a(coop_a1), .coop_b(coop_b1),
    .busy(busy1), .done(done1), .timeout_err(timeout_err1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) check("d0_spurious_done", done0, 0);
      else begin
        e = q0.pop_front();
        check("d0_score_a", score_a0, e.sa);
        check("d0_score_b", score_b0, e.sb);
        check("d0_coop_a", coop_a0, e.ca);
        check("d0_coop_b", coop_b0, e.cb);
        check("d0_timeout_err", timeout_err0, e.te);
      end
    end
  end
  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) check("d1_spurious_done", done1, 0);
      else begin
        e = q1.pop_front();
        check("d1_score_a", score_a1, e.sa);
        check("d1_score_b", score_b1, e.sb);
        check("d1_coop_a", coop_a1, e.ca);
        check("d1_coop_b", coop_b1, e.cb);
        check("d1_timeout_err", timeout_err1, e.te);
      end
    end
  end
  task automatic start_match(input bit d, input logic [7:0] c);
    if (d) begin start1 = 1; cfg1 = c; end
    else begin start0 = 1; cfg0 = c; end
    @(negedge clk);
    start0 = 0;
    start1 = 0;
  endtask
  task automatic wait_done(input bit d, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (d ? done1 : done0) return;
    end
    check(d ? "d1_done_timeout" : "d0_done_timeout", d ? done1 : done0, 1);
  endtask
  task automatic wait_req(input bit d);
    for (int i = 0; i < 50; i++) begin
      if (d ? round_req1 : round_req0) return;
      @(negedge clk);
    end
    check(d ? "d1_req_timeout" : "d0_req_timeout", d ? round_req1 : round_req0, 1);
  endtask
  task automatic wait_idx0(input logic [7:0] v);
    for (int i = 0; i < 500; i++) begin
      if (round_idx0 == v) return;
      @(negedge clk);
    end
    check("d0_idx_timeout", round_idx0, v);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_score_a", score_a0, 0);
    check("rst_round_idx", round_idx0, 0);
    check("rst_round_req", round_req0, 0);
    check("rst_player_rst", player_rst0, 0);
    check("rst_last_round", last_round0, 0);
    check("rst_timeout_err", timeout_err0, 0);
    reset = 0;
    @(negedge clk);
    // Default-length match, mutual cooperation.
    av0 = 1; a0 = 0; bv0 = 1; b0 = 0;
    q0.push_back('{600, 600, 200, 200, 0});
    start_match(0, 8'd0);
    check("t1_player_rst", player_rst0, 1);
    check("t1_busy", busy0, 1);
    @(negedge clk);
    check("t1_player_rst_drop", player_rst0, 0);
    check("t1_round_req", round_req0, 1);
    wait_done(0, 1000);
    @(negedge clk);
    check("t1_idle", busy0, 0);
    // A always defects, B always cooperates; stray start mid-match.
    a0 = 1; b0 = 0;
    q0.push_back('{50, 0, 0, 10, 0});
    start_match(0, 8'd10);
    wait_idx0(8'd1);
    check("t2_opp_to_b", opp_to_b0, 1);
    check("t2_opp_to_a", opp_to_a0, 0);
    check("t2_not_last", last_round0, 0);
    start_match(0, 8'd3);
    wait_idx0(8'd9);
    check("t2_last_round", last_round0, 1);
    wait_done(0, 200);
    @(negedge clk);
    // Staggered valids: first A action must win.
    av0 = 0; bv0 = 0;
    q0.push_back('{3, 3, 1, 1, 0});
    start_match(0, 8'd1);
    wait_req(0);
    check("t5_last_round", last_round0, 1);
    for (int k = 0; k < 6; k++) begin
      av0 = (k == 0) || (k == 3);
      a0  = (k == 3);
      bv0 = (k == 5);
      b0  = 0;
      @(negedge clk);
      if (k == 4) check("t5_still_req", round_req0, 1);
      if (k == 5) check("t5_score_entry", round_req0, 0);
    end
    av0 = 0; bv0 = 0;
    wait_done(0, 50);
    @(negedge clk);
    // Reset mid-match aborts with no done pulse.
    av0 = 1; a0 = 0; bv0 = 1; b0 = 0;
    start_match(0, 8'd20);
    wait_idx0(8'd5);
    reset = 1;
    #1;
    check("t6_async_busy", busy0, 0);
    @(negedge clk);
    check("t6_score_a", score_a0, 0);
    check("t6_round_idx", round_idx0, 0);
    check("t6_coop_a", coop_a0, 0);
    check("t6_round_req", round_req0, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    check("t6_no_done", done0, 0);
    // Clean restart.
    a0 = 0; b0 = 1;
    q0.push_back('{0, 10, 2, 0, 0});
    start_match(0, 8'd2);
    wait_req(0);
    check("t7_round_idx", round_idx0, 0);
    wait_done(0, 50);
    @(negedge clk);
    // B never answers: each round times out after 8 REQ cycles.
    av1 = 1; a1 = 0; bv1 = 0;
    q1.push_back('{0, 15, 3, 0, 1});
    start_match(1, 8'd3);
    wait_req(1);
    n = 0;
    while (round_req1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t3_req_cycles", n, 8);
    wait_done(1, 100);
    @(negedge clk);
    // Saturation of a 4-bit score.
    a1 = 1; bv1 = 1; b1 = 0;
    q1.push_back('{15, 0, 0, 4, 0});
    start_match(1, 8'd4);
    wait_done(1, 100);
    @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ipd_match_ctrl.md
Name: ipd_match_ctrl

Overview:
Sequences one iterated Prisoner's Dilemma match between two player blocks (A and B). It resets the players, requests one action per round from each with a valid handshake, and feeds each player the opponent's previous action. It also accumulates payoffs and cooperation counts and signals match completion. It sits above the player strategy modules in the tournament fabric. Action encoding: 0 = cooperate, 1 = defect.

Parameters:
NUM_ROUNDS, 200, default match length used when cfg_rounds == 0
ROUND_W, 8, width of round counters and cfg_rounds
SCORE_W, 16, width of score accumulators
PAY_T, 5, temptation payoff (defect vs cooperate)
PAY_R, 3, reward payoff (both cooperate)
PAY_P, 1, punishment payoff (both defect)
PAY_S, 0, sucker payoff (cooperate vs defect)
TIMEOUT, 15, max cycles to wait for a player action

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  begin match; honoured only in IDLE
cfg_rounds  in  ROUND_W  match length, sampled on start; 0 selects NUM_ROUNDS
player_rst  out  1  one-cycle pulse resetting both players
round_req  out  1  asking players for this round's action
act_a_valid  in  1  A action valid
act_a  in  1  A action
act_b_valid  in  1  B action valid
act_b  in  1  B action
opp_to_a  out  1  B's previous action, presented to A
opp_to_b  out  1  A's previous action, presented to B
round_idx  out  ROUND_W  current round number, 0-based
last_round  out  1  high while round_idx == rounds-1
score_a  out  SCORE_W  accumulated A payoff
score_b  out  SCORE_W  accumulated B payoff
coop_a  out  ROUND_W  rounds in which A cooperated
coop_b  out  ROUND_W  rounds in which B cooperated
busy  out  1  match in progress (not IDLE)
done  out  1  one-cycle pulse at match end
timeout_err  out  1  sticky: some action was substituted by timeout

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, INIT, REQ, SCORE, UPDATE, DONE.
- IDLE: start=1 latches rounds (cfg_rounds, or NUM_ROUNDS if 0). Also clears score_a/b, coop_a/b, round_idx, opp_to_a/b and timeout_err, then moves to INIT. Scores otherwise hold after a match.
- INIT: player_rst=1 for exactly one cycle, then REQ.
- REQ: round_req=1.
  - Each player's action is latched independently on the first cycle its valid is high. Later valids from that player in the same round are ignored.
  - When both actions are latched (including a same-cycle arrival), go to SCORE.
  - A wait counter starts at 0 on REQ entry. If it reaches TIMEOUT-1 with an action still missing, that action is forced to 1 (defect), timeout_err is set, and the FSM goes to SCORE.
- SCORE: compute payoff from the latched pair.
  - (0,0) gives R,R; (0,1) gives S,T; (1,0) gives T,S; (1,1) gives P,P.
  - Add to score_a/score_b with saturation at 2^SCORE_W-1; no wrap.
  - Increment coop_x when that player's action was 0.
- UPDATE: opp_to_a <= B action; opp_to_b <= A action.
  - If round_idx == rounds-1, go to DONE.
  - Otherwise round_idx++ and go to REQ.
- DONE: done=1 for one cycle, then IDLE.
- busy = 1 in every state except IDLE.
- Minimum round period is 3 cycles (REQ, SCORE, UPDATE) when both valids are high on the first REQ cycle.
- start outside IDLE is ignored. start held high in IDLE on the cycle done drops starts a new match.
- rounds = 1 is legal: a single REQ/SCORE/UPDATE, then DONE. last_round is high during that round.
- Reset mid-match aborts immediately; no done pulse; all outputs return to reset values.

Test Plan:
- cfg_rounds=0, both players always valid with action 0 -> done after 200 rounds; score_a=score_b=600; coop_a=coop_b=200; timeout_err=0.
- cfg_rounds=10, A always 1, B always 0 -> score_a=50, score_b=0, coop_a=0, coop_b=10. opp_to_b=1 from round 1 onward.
- cfg_rounds=3, TIMEOUT=8, A valid action 0, B never valid -> each round lasts 8 REQ cycles; B forced to defect; score_a=0, score_b=15; timeout_err=1.
- SCORE_W=4, cfg_rounds=4, A always 1, B always 0 -> score_a saturates at 15 (not 20 mod 16 = 4); score_b=0.
- Valids staggered (A at REQ cycle 0, B at cycle 5; A re-pulses valid with a different action at cycle 3) -> first A action used; SCORE entered one cycle after B valid.
- start pulsed while busy -> ignored, match length unchanged. Reset asserted at round 5 -> busy=0, scores 0, no done pulse. A new start runs cleanly from round 0.
